// File: rtl/frankie_io_pkg.sv
// Shared defaults and status-word layout for the frankie IO hub.
package frankie_io_pkg;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_CHANNELS = 4;
   localparam int DEF_IN_DEPTH = 4;

   // Status word is {underflow, full, nonempty}; field offset = index * CHANNELS.
   localparam int STAT_NONEMPTY_IDX  = 0;
   localparam int STAT_FULL_IDX      = 1;
   localparam int STAT_UNDERFLOW_IDX = 2;

   function automatic int stat_off(input int idx, input int channels);
      return idx * channels;
   endfunction

endpackage

// File: rtl/frankie_io_fifo.sv
// Per-channel synchronous FIFO: head is visible combinationally, push/pop take effect on the edge.
// Push when full and pop when empty are ignored, so the caller decides what those mean.
module frankie_io_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_dat,
   input  logic              pop,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] head
);

   localparam int PW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [PW:0]       count_q;
   logic              do_push, do_pop;

   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/frankie_io_hub.sv
// IO hub: per-channel input FIFOs read by the core, output latches written by it; reads answer one cycle later.
// External pushes back off via io_in_ready; optional write-to-FIFO loopback under FRANKIE_IO_LOOPBACK_EN.
module frankie_io_hub
   import frankie_io_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int IN_DEPTH = DEF_IN_DEPTH
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [$clog2(CHANNELS):0]    io_addr,
   input  logic                         io_rd,
   input  logic                         io_wr,
   input  logic [DATA_W-1:0]            io_wdata,
   output logic [DATA_W-1:0]            io_rdata,
   output logic                         io_rvalid,
   input  logic [CHANNELS*DATA_W-1:0]   io_in,
   input  logic [CHANNELS-1:0]          io_in_valid,
   output logic [CHANNELS-1:0]          io_in_ready,
   output logic [CHANNELS*DATA_W-1:0]   io_out,
   output logic [CHANNELS-1:0]          io_out_strobe
);

   localparam int AW   = $clog2(CHANNELS) + 1;
   localparam int SELW = AW - 1;
   localparam int SW   = 3 * CHANNELS;

   logic [DATA_W-1:0]   head     [CHANNELS];
   logic [DATA_W-1:0]   push_dat [CHANNELS];
   logic [DATA_W-1:0]   out_q    [CHANNELS];
   logic [CHANNELS-1:0] full, empty, push, pop, hit, lb_push;
   logic [CHANNELS-1:0] underflow_q, underflow_d, strobe_q, strobe_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                rvalid_q;
   logic [SW-1:0]       stat;

   always_comb begin
      hit = '0;
      for (int c = 0; c < CHANNELS; c++) hit[c] = (io_addr[SELW-1:0] == SELW'(c));
   end

   always_comb begin
      stat = '0;
      stat[stat_off(STAT_NONEMPTY_IDX, CHANNELS)  +: CHANNELS] = ~empty;
      stat[stat_off(STAT_FULL_IDX, CHANNELS)      +: CHANNELS] = full;
      stat[stat_off(STAT_UNDERFLOW_IDX, CHANNELS) +: CHANNELS] = underflow_q;
   end

   // A read wins over a simultaneous write, so writes only decode when io_rd is low.
   always_comb begin
      rdata_d     = '0;
      underflow_d = underflow_q;
      strobe_d    = '0;
      pop         = '0;
      if (io_rd) begin
         if (io_addr[AW-1]) begin
            rdata_d     = DATA_W'(stat);
            underflow_d = '0;
         end else begin
            for (int c = 0; c < CHANNELS; c++) begin
               if (hit[c]) begin
                  if (empty[c]) underflow_d[c] = 1'b1;
                  else begin
                     rdata_d = head[c];
                     pop[c]  = 1'b1;
                  end
               end
            end
         end
      end else if (io_wr && !io_addr[AW-1]) begin
         strobe_d = hit;
      end
   end

`ifdef FRANKIE_IO_LOOPBACK_EN
   logic [CHANNELS-1:0] loopback_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) loopback_q <= '0;
      else if (io_wr && !io_rd && io_addr[AW-1]) loopback_q <= io_wdata[CHANNELS-1:0];
   end

   assign io_in_ready = ~full & ~loopback_q;
   assign lb_push     = strobe_d & loopback_q & ~full;
`else
   assign io_in_ready = ~full;
   assign lb_push     = '0;
`endif

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign push[c]     = (io_in_valid[c] && io_in_ready[c]) || lb_push[c];
      assign push_dat[c] = lb_push[c] ? io_wdata : io_in[c*DATA_W +: DATA_W];
      assign io_out[c*DATA_W +: DATA_W] = out_q[c];

      frankie_io_fifo #(.DATA_W(DATA_W), .DEPTH(IN_DEPTH)) u_fifo (
         .clock    (clock),
         .reset    (reset),
         .push     (push[c]),
         .push_dat (push_dat[c]),
         .pop      (pop[c]),
         .full     (full[c]),
         .empty    (empty[c]),
         .head     (head[c])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         underflow_q <= '0;
         strobe_q    <= '0;
         for (int c = 0; c < CHANNELS; c++) out_q[c] <= '0;
      end else begin
         rdata_q     <= rdata_d;
         rvalid_q    <= io_rd;
         underflow_q <= underflow_d;
         strobe_q    <= strobe_d;
         for (int c = 0; c < CHANNELS; c++) if (strobe_d[c]) out_q[c] <= io_wdata;
      end
   end

   assign io_rdata      = rdata_q;
   assign io_rvalid     = rvalid_q;
   assign io_out_strobe = strobe_q;

endmodule

// File: tb/tb_frankie_io_hub.sv
// Directed bench for frankie_io_hub (default parameters); loopback steps follow FRANKIE_IO_LOOPBACK_EN.
module tb_frankie_io_hub;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  io_addr = '0;
   logic        io_rd = 1'b0;
   logic        io_wr = 1'b0;
   logic [15:0] io_wdata = '0;
   logic [15:0] io_rdata;
   logic        io_rvalid;
   logic [63:0] io_in = '0;
   logic [3:0]  io_in_valid = '0;
   logic [3:0]  io_in_ready;
   logic [63:0] io_out;
   logic [3:0]  io_out_strobe;

   int checks   = 0;
   int failures = 0;

   frankie_io_hub dut (
      .clock         (clock),
      .reset         (reset),
      .io_addr       (io_addr),
      .io_rd         (io_rd),
      .io_wr         (io_wr),
      .io_wdata      (io_wdata),
      .io_rdata      (io_rdata),
      .io_rvalid     (io_rvalid),
      .io_in         (io_in),
      .io_in_valid   (io_in_valid),
      .io_in_ready   (io_in_ready),
      .io_out        (io_out),
      .io_out_strobe (io_out_strobe)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input int ch, input logic [15:0] d);
      io_in[ch*16 +: 16] = d;
      io_in_valid[ch]    = 1'b1;
      tick();
      io_in_valid = '0;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
      io_addr = a;
      io_rd   = 1'b1;
      tick();
      io_rd   = 1'b0;
      check({tag, "_rvalid"}, {63'd0, io_rvalid}, 64'd1);
      check(tag, {48'd0, io_rdata}, {48'd0, exp});
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      io_addr  = a;
      io_wdata = d;
      io_wr    = 1'b1;
      tick();
      io_wr    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      #2;
      check("rst_rdata", {48'd0, io_rdata}, 64'd0);
      check("rst_rvalid", {63'd0, io_rvalid}, 64'd0);
      check("rst_out", io_out, 64'd0);
      check("rst_strobe", {60'd0, io_out_strobe}, 64'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      tick();
      check("ready_after_rst", {60'd0, io_in_ready}, 64'hF);

      // single push then read, one-cycle latency
      push(0, 16'h0010);
      rd_chk("rd_ch0", 3'd0, 16'h0010);
      tick();
      check("rvalid_drop", {63'd0, io_rvalid}, 64'd0);

      // fill channel 1 past depth
      push(1, 16'h1001);
      push(1, 16'h1002);
      push(1, 16'h1003);
      check("ready1_3", {63'd0, io_in_ready[1]}, 64'd1);
      push(1, 16'h1004);
      check("ready1_full", {63'd0, io_in_ready[1]}, 64'd0);
      push(1, 16'h1005);
      rd_chk("stat_full", 3'd4, 16'h0022);
      rd_chk("rd_ch1_a", 3'd1, 16'h1001);
      rd_chk("rd_ch1_b", 3'd1, 16'h1002);
      rd_chk("rd_ch1_c", 3'd1, 16'h1003);
      rd_chk("rd_ch1_d", 3'd1, 16'h1004);
      rd_chk("rd_ch1_drop", 3'd1, 16'h0000);
      rd_chk("stat_uf1", 3'd4, 16'h0200);

      // underflow on empty channel 2 is sticky until a status read
      rd_chk("rd_ch2_empty", 3'd2, 16'h0000);
      rd_chk("stat_uf2", 3'd4, 16'h0400);
      rd_chk("stat_uf2_clr", 3'd4, 16'h0000);

      // output latches and strobes
      wr(3'd3, 16'h7FFF);
      check("out_ch3", io_out, 64'h7FFF_0000_0000_0000);
      check("strobe_ch3", {60'd0, io_out_strobe}, 64'h8);
      tick();
      check("strobe_ch3_off", {60'd0, io_out_strobe}, 64'h0);
      check("out_ch3_hold", io_out, 64'h7FFF_0000_0000_0000);
      wr(3'd1, 16'h00AB);
      check("out_ch1", io_out, 64'h7FFF_0000_00AB_0000);
      check("strobe_ch1", {60'd0, io_out_strobe}, 64'h2);

      // push and pop same cycle on empty channel: read sees 0, word kept
      io_in[47:32] = 16'h2222;
      io_in_valid  = 4'b0100;
      rd_chk("pp_empty", 3'd2, 16'h0000);
      io_in_valid  = '0;
      io_addr = 3'd4;
      io_rd   = 1'b1;
      tick();
      io_rd   = 1'b0;
      check("pp_empty_stat", {56'd0, io_rdata[7:0]}, 64'h04);
      // push and pop same cycle on non-empty channel
      io_in[47:32] = 16'h3333;
      io_in_valid  = 4'b0100;
      rd_chk("pp_full", 3'd2, 16'h2222);
      io_in_valid  = '0;
      rd_chk("pp_stat", 3'd4, 16'h0004);
      rd_chk("pp_second", 3'd2, 16'h3333);
      rd_chk("pp_stat_empty", 3'd4, 16'h0000);

      // read and write together: only the read happens
      io_addr  = 3'd0;
      io_wdata = 16'h5555;
      io_rd    = 1'b1;
      io_wr    = 1'b1;
      tick();
      io_rd    = 1'b0;
      io_wr    = 1'b0;
      check("rdwr_rdata", {48'd0, io_rdata}, 64'd0);
      check("rdwr_strobe", {60'd0, io_out_strobe}, 64'h0);
      check("rdwr_out", io_out, 64'h7FFF_0000_00AB_0000);
      rd_chk("rdwr_stat", 3'd4, 16'h0100);

      // control write and loopback
      wr(3'd4, 16'h0001);
      check("ctl_strobe", {60'd0, io_out_strobe}, 64'h0);
`ifdef FRANKIE_IO_LOOPBACK_EN
      check("lb_ready", {60'd0, io_in_ready}, 64'hE);
      wr(3'd0, 16'h0037);
      check("lb_strobe", {60'd0, io_out_strobe}, 64'h1);
      check("lb_out", io_out, 64'h7FFF_0000_00AB_0037);
      rd_chk("lb_rd", 3'd0, 16'h0037);
      wr(3'd4, 16'h0000);
      check("lb_ready_off", {60'd0, io_in_ready}, 64'hF);
`else
      check("nolb_ready", {60'd0, io_in_ready}, 64'hF);
      wr(3'd0, 16'h0037);
      check("nolb_strobe", {60'd0, io_out_strobe}, 64'h1);
      check("nolb_out", io_out, 64'h7FFF_0000_00AB_0037);
      rd_chk("nolb_rd", 3'd0, 16'h0000);
`endif

      // asynchronous reset mid-stream
      push(0, 16'h00A1);
      push(0, 16'h00A2);
      push(0, 16'h00A3);
      io_addr = 3'd0;
      io_rd   = 1'b1;
      tick();
      io_rd   = 1'b0;
      check("pre_rst_rd", {48'd0, io_rdata}, 64'h00A1);
      #2 reset = 1'b0;
      #1;
      check("arst_rvalid", {63'd0, io_rvalid}, 64'd0);
      check("arst_rdata", {48'd0, io_rdata}, 64'd0);
      check("arst_out", io_out, 64'd0);
      @(posedge clock);
      #1 reset = 1'b1;
      tick();
      check("post_rst_ready", {60'd0, io_in_ready}, 64'hF);
      rd_chk("post_rst_stat", 3'd4, 16'h0000);
      rd_chk("post_rst_rd", 3'd0, 16'h0000);
      rd_chk("post_rst_uf", 3'd4, 16'h0100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/frankie_io_hub.md
FRANKIE_IO_HUB -- requirements
Module: frankie_io_hub

Interface
REQ-001 Parameter DATA_W, default 16: width of every IO data word.
REQ-002 Parameter CHANNELS, default 4, range 2..8: number of independent IO channels.
REQ-003 Parameter IN_DEPTH, default 4, power of two >= 2: entries per channel input FIFO.
REQ-004 Port clock, input, 1: sole clock, rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port io_addr, input, $clog2(CHANNELS)+1: MSB=0 selects data channel io_addr[low bits]; MSB=1 selects status (read) or control (write).
REQ-007 Port io_rd, input, 1: core read request, single-cycle pulse.
REQ-008 Port io_wr, input, 1: core write request, single-cycle pulse.
REQ-009 Port io_wdata, input, DATA_W: core write data.
REQ-010 Port io_rdata, output, DATA_W: registered read data.
REQ-011 Port io_rvalid, output, 1: io_rdata valid this cycle.
REQ-012 Port io_in, input, CHANNELS*DATA_W: external input words, channel c at bits [c*DATA_W +: DATA_W].
REQ-013 Port io_in_valid, input, CHANNELS: per-channel external push request.
REQ-014 Port io_in_ready, output, CHANNELS: per-channel push acceptance.
REQ-015 Port io_out, output, CHANNELS*DATA_W: registered per-channel output latches.
REQ-016 Port io_out_strobe, output, CHANNELS: one-cycle pulse when the matching io_out word updates.

Function
REQ-017 External push into channel c SHALL occur on a clock edge where io_in_valid[c] && io_in_ready[c]; io_in_ready[c] = !full[c] && !loopback[c] (combinational).
REQ-018 Data read (io_rd, MSB=0) SHALL pop the selected FIFO head and present it on io_rdata with io_rvalid high exactly one cycle later.
REQ-019 Data read of an empty channel SHALL return 0 with io_rvalid high, no pop, and set sticky underflow[c].
REQ-020 Simultaneous push and pop on one channel SHALL both occur; count unchanged unless empty, in which case read returns 0 (read-before-write) and count becomes 1.
REQ-021 Data write (io_wr, MSB=0) SHALL load io_out channel on the next edge and pulse io_out_strobe[c] that same cycle.
REQ-022 Status read SHALL return {underflow[CHANNELS-1:0], full[CHANNELS-1:0], nonempty[CHANNELS-1:0]} zero-extended to DATA_W, one-cycle latency, and clear all underflow bits.
REQ-023 Control write SHALL load loopback[CHANNELS-1:0] from io_wdata[CHANNELS-1:0].
REQ-024 FIFO pointers SHALL be $clog2(IN_DEPTH) bits, wrap modulo IN_DEPTH; count SHALL be $clog2(IN_DEPTH)+1 bits saturating at IN_DEPTH.
REQ-025 io_rd and io_wr asserted together SHALL execute the read only; the write is discarded.

Reset
REQ-026 While reset low: io_rdata=0, io_rvalid=0, io_out=0, io_out_strobe=0, all FIFOs empty, underflow=0, loopback=0; io_in_ready SHALL read all-ones one cycle after release.
REQ-027 Reset asserted mid-operation SHALL discard all buffered words and any pending read immediately (asynchronous).

Configuration
REQ-028 With FRANKIE_IO_LOOPBACK_EN defined, a data write to channel c with loopback[c]=1 SHALL also push io_wdata into FIFO c (dropped and underflow[c] untouched if full), in addition to REQ-021.
REQ-029 Without FRANKIE_IO_LOOPBACK_EN, loopback register SHALL not exist, control writes SHALL be ignored, and io_in_ready[c] = !full[c].

Structure
REQ-030 Package frankie_io_pkg SHALL hold default DATA_W/CHANNELS/IN_DEPTH constants and the status-word field offsets.
REQ-031 Sub-module frankie_io_fifo (one instance per channel, generate loop) SHALL implement the synchronous FIFO with push, pop, full, empty, head.

Verification
REQ-032 Push 0x0010 on channel 0, then data read addr 0 -> io_rdata=0x0010, io_rvalid one cycle after io_rd.
REQ-033 Push 5 words on channel 1 (IN_DEPTH=4) -> io_in_ready[1] low after 4th; status read shows full[1]=1; reads return first 4 in order.
REQ-034 Read empty channel 2, then status read -> io_rdata=0, underflow[2]=1; second status read shows underflow[2]=0.
REQ-035 Write 0x7FFF to channel 3 -> io_out[3]=0x7FFF, io_out_strobe[3] high one cycle only; other channels unchanged.
REQ-036 LOOPBACK_EN: control write 0x1, data write 0x0037 to channel 0, data read channel 0 -> 0x0037; io_in_ready[0]=0 while enabled.
REQ-037 Fill channel 0 with 3 words, assert reset for one cycle mid-stream -> io_out=0, status read returns 0, read returns 0 with underflow.
